// File: rtl/pwm_cfg_sequencer.sv
// pwm_cfg_sequencer: register-bus front end for a PWM core.
// Software writes land in shadow registers. They are copied to the active
// registers that drive the core only at period boundaries, so the core never
// sees a half-updated configuration. The duty cycle can optionally slew toward
// its target by a bounded step per period. Start and graceful stop are sequenced
// by a four-state FSM: IDLE, START, RUN, STOP.
module pwm_cfg_sequencer #(
    parameter int W         = 16,
    parameter int RAMP_STEP = 16,
    parameter int STOP_TO   = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [1:0]   cfg_addr,
    input  logic [W-1:0] cfg_wdata,
    input  logic [1:0]   rd_addr,
    output logic [W-1:0] rd_data,
    input  logic         period_done,
    output logic [W-1:0] period,
    output logic [W-1:0] duty_cycle,
    output logic [W-1:0] prescaler,
    output logic         enable,
    output logic         upd_done,
    output logic         busy
);

    localparam int             CW        = $clog2(STOP_TO + 1);
    localparam logic [CW-1:0]  STOP_LAST = CW'(STOP_TO - 1);
    localparam logic [W:0]     STEP_X    = (W + 1)'(RAMP_STEP);

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PERIOD = 2'd1;
    localparam logic [1:0] A_DUTY   = 2'd2;
    localparam logic [1:0] A_PRESC  = 2'd3;

    // The encoding is software-visible through the CTRL read-back.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] stop_cnt_q, stop_cnt_d;

    logic          run_req_q, run_req_d;
    logic          ramp_en_q, ramp_en_d;
    logic          dirty_q, dirty_d;
    logic [W-1:0]  sh_period_q, sh_period_d;
    logic [W-1:0]  sh_duty_q, sh_duty_d;
    logic [W-1:0]  sh_presc_q, sh_presc_d;

    logic [W-1:0]  period_q, period_d;
    logic [W-1:0]  duty_q, duty_d;
    logic [W-1:0]  tgt_q, tgt_d;
    logic [W-1:0]  presc_q, presc_d;
    logic          upd_q, upd_d;
    logic [W-1:0]  rd_data_q, rd_data_d;

    logic          wr_en;
    logic          commit;
    logic [W-1:0]  per_new;
    logic [W-1:0]  tgt_new;
    logic [W-1:0]  limit;

    function automatic logic [W-1:0] min_w(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Move cur toward lim by at most RAMP_STEP. The extra bit keeps cur+STEP
    // from wrapping, and the result lands exactly on lim instead of overshooting.
    function automatic logic [W-1:0] ramp_toward(input logic [W-1:0] cur, input logic [W-1:0] lim);
        logic [W:0]   cur_x;
        logic [W:0]   lim_x;
        logic [W:0]   up_x;
        logic [W:0]   dn_x;
        logic [W-1:0] res;
        cur_x = {1'b0, cur};
        lim_x = {1'b0, lim};
        up_x  = cur_x + STEP_X;
        dn_x  = cur_x - STEP_X;
        if (cur_x < lim_x) begin
            res = (up_x > lim_x) ? lim : up_x[W-1:0];
        end else if ((cur_x - lim_x) > STEP_X) begin
            res = dn_x[W-1:0];
        end else begin
            res = lim;
        end
        return res;
    endfunction

    assign cfg_ready  = (state_q != ST_STOP);
    assign enable     = (state_q == ST_RUN) || (state_q == ST_STOP);
    assign busy       = (state_q == ST_START) || (state_q == ST_STOP);
    assign period     = period_q;
    assign duty_cycle = duty_q;
    assign prescaler  = presc_q;
    assign upd_done   = upd_q;
    assign rd_data    = rd_data_q;

    // FSM next state and the stop-timeout counter.
    always_comb begin
        state_d    = state_q;
        stop_cnt_d = stop_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (run_req_q) state_d = ST_START;
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!run_req_q) begin
                    state_d    = ST_STOP;
                    stop_cnt_d = '0;
                end
            end
            ST_STOP: begin
                stop_cnt_d = stop_cnt_q + CW'(1);
                if (period_done || (stop_cnt_q == STOP_LAST)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            stop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            stop_cnt_q <= stop_cnt_d;
        end
    end

    // Datapath: shadow writes, commits to the active set, duty slewing, read mux.
    always_comb begin
        run_req_d   = run_req_q;
        ramp_en_d   = ramp_en_q;
        dirty_d     = dirty_q;
        sh_period_d = sh_period_q;
        sh_duty_d   = sh_duty_q;
        sh_presc_d  = sh_presc_q;
        period_d    = period_q;
        duty_d      = duty_q;
        tgt_d       = tgt_q;
        presc_d     = presc_q;
        upd_d       = 1'b0;
        rd_data_d   = '0;

        wr_en   = cfg_valid && cfg_ready;
        // A commit always uses the pre-write shadow, so a write in the same
        // cycle is kept for the next boundary.
        commit  = (state_q == ST_START) ||
                  ((state_q == ST_RUN) && period_done && dirty_q);
        per_new = commit ? sh_period_q : period_q;
        tgt_new = commit ? sh_duty_q   : tgt_q;
        limit   = min_w(tgt_new, per_new);

        if (state_q == ST_START) begin
            duty_d = limit;
        end else if ((state_q == ST_RUN) && period_done) begin
            if (ramp_en_q) begin
                // A shrinking period can leave duty above the new period, so clamp.
                duty_d = min_w(ramp_toward(duty_q, limit), per_new);
            end else if (dirty_q) begin
                duty_d = limit;
            end
        end

        if (commit) begin
            period_d = sh_period_q;
            presc_d  = sh_presc_q;
            tgt_d    = sh_duty_q;
            upd_d    = 1'b1;
            dirty_d  = 1'b0;
        end

        if (wr_en) begin
            unique case (cfg_addr)
                A_CTRL: begin
                    run_req_d = cfg_wdata[0];
                    ramp_en_d = cfg_wdata[1];
                end
                A_PERIOD: begin
                    sh_period_d = cfg_wdata;
                    dirty_d     = 1'b1;
                end
                A_DUTY: begin
                    sh_duty_d = cfg_wdata;
                    dirty_d   = 1'b1;
                end
                default: begin
                    sh_presc_d = cfg_wdata;
                    dirty_d    = 1'b1;
                end
            endcase
        end

        unique case (rd_addr)
            A_CTRL:   rd_data_d = W'({state_q, dirty_q, ramp_en_q, run_req_q});
            A_PERIOD: rd_data_d = sh_period_q;
            A_DUTY:   rd_data_d = sh_duty_q;
            default:  rd_data_d = sh_presc_q;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_req_q   <= 1'b0;
            ramp_en_q   <= 1'b0;
            dirty_q     <= 1'b0;
            sh_period_q <= '0;
            sh_duty_q   <= '0;
            sh_presc_q  <= '0;
            period_q    <= '0;
            duty_q      <= '0;
            tgt_q       <= '0;
            presc_q     <= '0;
            upd_q       <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            run_req_q   <= run_req_d;
            ramp_en_q   <= ramp_en_d;
            dirty_q     <= dirty_d;
            sh_period_q <= sh_period_d;
            sh_duty_q   <= sh_duty_d;
            sh_presc_q  <= sh_presc_d;
            period_q    <= period_d;
            duty_q      <= duty_d;
            tgt_q       <= tgt_d;
            presc_q     <= presc_d;
            upd_q       <= upd_d;
            rd_data_q   <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Testbench for pwm_cfg_sequencer.
// It applies a directed vector table, then hand-written multi-cycle sequences,
// then randomized traffic compared against a behavioural model.
module tb_pwm_cfg_sequencer;

    localparam int W   = 16;
    localparam int RS  = 16;
    localparam int STO = 40;

    localparam int M_IDLE  = 0;
    localparam int M_START = 1;
    localparam int M_RUN   = 2;
    localparam int M_STOP  = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [1:0]   cfg_addr;
    logic [W-1:0] cfg_wdata;
    logic [1:0]   rd_addr;
    logic [W-1:0] rd_data;
    logic         period_done;
    logic [W-1:0] period;
    logic [W-1:0] duty_cycle;
    logic [W-1:0] prescaler;
    logic         enable;
    logic         upd_done;
    logic         busy;

    int tests = 0;
    int fails = 0;

    pwm_cfg_sequencer #(.W(W), .RAMP_STEP(RS), .STOP_TO(STO)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .rd_addr(rd_addr), .rd_data(rd_data),
        .period_done(period_done), .period(period), .duty_cycle(duty_cycle),
        .prescaler(prescaler), .enable(enable), .upd_done(upd_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [1:0]  a;
        logic [15:0] d;
        logic        pd;
        logic        en;
        logic [15:0] per;
        logic [15:0] duty;
        logic        upd;
        logic        bsy;
    } vec_t;

    vec_t vecs [15];

    // Behavioural model state, kept as plain integers.
    int m_mode, m_run, m_ramp, m_dirty;
    int m_sh_per, m_sh_duty, m_sh_pre;
    int m_per, m_duty, m_tgt, m_pre, m_upd, m_rd, m_stop_n;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] a, input int d, input logic pd);
        cfg_valid   = v;
        cfg_addr    = a;
        cfg_wdata   = W'(d);
        period_done = pd;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 0, 1'b0);
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int ramp_to(input int cur, input int lim);
        if (cur < lim) return imin(cur + RS, lim);
        return (cur - RS < lim) ? lim : cur - RS;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge(input logic rst, input logic v, input logic [1:0] a,
                              input int d, input logic pd, input logic [1:0] ra);
        int  per_n, tgt_n, pre_n, limit;
        logic commit, wr;
        if (rst) begin
            m_mode = M_IDLE; m_run = 0; m_ramp = 0; m_dirty = 0;
            m_sh_per = 0; m_sh_duty = 0; m_sh_pre = 0;
            m_per = 0; m_duty = 0; m_tgt = 0; m_pre = 0; m_upd = 0; m_rd = 0; m_stop_n = 0;
            return;
        end
        wr = v && (m_mode != M_STOP);
        case (ra)
            2'd0:    m_rd = m_mode * 8 + m_dirty * 4 + m_ramp * 2 + m_run;
            2'd1:    m_rd = m_sh_per;
            2'd2:    m_rd = m_sh_duty;
            default: m_rd = m_sh_pre;
        endcase
        commit = (m_mode == M_START) || (m_mode == M_RUN && pd && m_dirty != 0);
        per_n  = commit ? m_sh_per  : m_per;
        tgt_n  = commit ? m_sh_duty : m_tgt;
        pre_n  = commit ? m_sh_pre  : m_pre;
        limit  = imin(tgt_n, per_n);
        if (m_mode == M_START) m_duty = limit;
        else if (m_mode == M_RUN && pd) begin
            if (m_ramp != 0) m_duty = imin(ramp_to(m_duty, limit), per_n);
            else if (m_dirty != 0) m_duty = limit;
        end
        m_per = per_n; m_tgt = tgt_n; m_pre = pre_n;
        m_upd = commit ? 1 : 0;
        if (commit) m_dirty = 0;
        case (m_mode)
            M_IDLE:  if (m_run != 0) m_mode = M_START;
            M_START: m_mode = M_RUN;
            M_RUN:   if (m_run == 0) begin m_mode = M_STOP; m_stop_n = 0; end
            default: begin
                m_stop_n++;
                if (pd || m_stop_n >= STO) m_mode = M_IDLE;
            end
        endcase
        if (wr) begin
            case (a)
                2'd0:    begin m_run = d & 1; m_ramp = (d >> 1) & 1; end
                2'd1:    begin m_sh_per  = d; m_dirty = 1; end
                2'd2:    begin m_sh_duty = d; m_dirty = 1; end
                default: begin m_sh_pre  = d; m_dirty = 1; end
            endcase
        end
    endtask

    initial begin
        int exp_up [5];
        int exp_dn [3];
        int stop_cycles;
        int done;
        logic       r_rst, r_v, r_pd;
        logic [1:0] r_a, r_ra;
        int         r_d;

        // PERIOD=100 DUTY=30 start, DUTY=60 update, DUTY=200 clamp, PERIOD=0.
        vecs[0]  = '{1'b1, 2'd1, 16'd100, 1'b0, 1'b0, 16'd0,   16'd0,   1'b0, 1'b0};
        vecs[1]  = '{1'b1, 2'd2, 16'd30,  1'b0, 1'b0, 16'd0,   16'd0,   1'b0, 1'b0};
        vecs[2]  = '{1'b1, 2'd0, 16'd1,   1'b0, 1'b0, 16'd0,   16'd0,   1'b0, 1'b0};
        vecs[3]  = '{1'b0, 2'd0, 16'd0,   1'b0, 1'b0, 16'd0,   16'd0,   1'b0, 1'b1};
        vecs[4]  = '{1'b0, 2'd0, 16'd0,   1'b0, 1'b1, 16'd100, 16'd30,  1'b1, 1'b0};
        vecs[5]  = '{1'b0, 2'd0, 16'd0,   1'b0, 1'b1, 16'd100, 16'd30,  1'b0, 1'b0};
        vecs[6]  = '{1'b1, 2'd2, 16'd60,  1'b0, 1'b1, 16'd100, 16'd30,  1'b0, 1'b0};
        vecs[7]  = '{1'b0, 2'd0, 16'd0,   1'b0, 1'b1, 16'd100, 16'd30,  1'b0, 1'b0};
        vecs[8]  = '{1'b0, 2'd0, 16'd0,   1'b1, 1'b1, 16'd100, 16'd60,  1'b1, 1'b0};
        vecs[9]  = '{1'b0, 2'd0, 16'd0,   1'b0, 1'b1, 16'd100, 16'd60,  1'b0, 1'b0};
        vecs[10] = '{1'b0, 2'd0, 16'd0,   1'b1, 1'b1, 16'd100, 16'd60,  1'b0, 1'b0};
        vecs[11] = '{1'b1, 2'd2, 16'd200, 1'b0, 1'b1, 16'd100, 16'd60,  1'b0, 1'b0};
        vecs[12] = '{1'b0, 2'd0, 16'd0,   1'b1, 1'b1, 16'd100, 16'd100, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 2'd1, 16'd0,   1'b0, 1'b1, 16'd100, 16'd100, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 2'd0, 16'd0,   1'b1, 1'b1, 16'd0,   16'd0,   1'b1, 1'b0};
        exp_up = '{16, 32, 48, 50, 50};
        exp_dn = '{34, 18, 10};

        // Reset state.
        reset = 1'b1; rd_addr = 2'd0; idle();
        repeat (3) cyc();
        chk("rst_enable", enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_upd", upd_done, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_period", period, 0);
        chk("rst_duty", duty_cycle, 0);
        chk("rst_presc", prescaler, 0);
        chk("rst_rd", rd_data, 0);
        reset = 1'b0;

        // Directed table.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].v, vecs[i].a, int'(vecs[i].d), vecs[i].pd);
            cyc();
            $display("[TB] vec %0d: v=%0d a=%0d d=%0d pd=%0d -> en=%0d per=%0d duty=%0d upd=%0d busy=%0d",
                     i, vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].pd, enable, period, duty_cycle, upd_done, busy);
            chk($sformatf("vec%0d_enable", i), enable, int'(vecs[i].en));
            chk($sformatf("vec%0d_period", i), period, int'(vecs[i].per));
            chk($sformatf("vec%0d_duty", i), duty_cycle, int'(vecs[i].duty));
            chk($sformatf("vec%0d_upd", i), upd_done, int'(vecs[i].upd));
            chk($sformatf("vec%0d_busy", i), busy, int'(vecs[i].bsy));
            chk($sformatf("vec%0d_ready", i), cfg_ready, 1);
        end
        idle();

        // Read-back of the shadow and CTRL registers.
        rd_addr = 2'd1; cyc(); chk("rd_period", rd_data, 0);
        rd_addr = 2'd2; cyc(); chk("rd_duty", rd_data, 200);
        rd_addr = 2'd0; cyc(); chk("rd_ctrl_run", rd_data, 17);
        $display("[TB] readback done");

        // Ramp up 0 -> 50 and back down to 10.
        drive(1'b1, 2'd0, 3, 1'b0);   cyc();
        drive(1'b1, 2'd1, 100, 1'b0); cyc();
        drive(1'b1, 2'd2, 50, 1'b0);  cyc();
        drive(1'b1, 2'd3, 7, 1'b0);   cyc();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 2'd0, 0, 1'b1); cyc();
            $display("[TB] ramp up step %0d duty=%0d", i, duty_cycle);
            chk($sformatf("ramp_up%0d_duty", i), duty_cycle, exp_up[i]);
            chk($sformatf("ramp_up%0d_upd", i), upd_done, (i == 0) ? 1 : 0);
        end
        chk("ramp_presc", prescaler, 7);
        chk("ramp_period", period, 100);
        drive(1'b1, 2'd2, 10, 1'b0); cyc();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'd0, 0, 1'b1); cyc();
            $display("[TB] ramp down step %0d duty=%0d", i, duty_cycle);
            chk($sformatf("ramp_dn%0d_duty", i), duty_cycle, exp_dn[i]);
        end

        // Stop without period_done: STOP_TO-cycle timeout, writes refused.
        drive(1'b1, 2'd0, 0, 1'b0); cyc(); idle();
        chk("stop_pre_enable", enable, 1);
        stop_cycles = 0;
        done = 0;
        for (int i = 0; i < STO + 10 && done == 0; i++) begin
            if (i >= 1 && i <= 3) drive(1'b1, 2'd1, 77, 1'b0);
            else idle();
            cyc();
            if (busy) begin
                stop_cycles++;
                if (i < 5) begin
                    chk("stop_ready", cfg_ready, 0);
                    chk("stop_enable", enable, 1);
                end
            end else begin
                done = 1;
            end
        end
        idle();
        chk("stop_exited", done, 1);
        chk("stop_length", stop_cycles, STO);
        chk("stop_exit_enable", enable, 0);
        rd_addr = 2'd1; cyc(); chk("stop_write_blocked", rd_data, 100);
        $display("[TB] timeout stop after %0d cycles", stop_cycles);

        // Restart, then stop early on period_done.
        drive(1'b1, 2'd0, 1, 1'b0); cyc(); idle(); cyc(); cyc();
        chk("restart_enable", enable, 1);
        chk("restart_duty", duty_cycle, 10);
        chk("restart_upd", upd_done, 1);
        drive(1'b1, 2'd0, 0, 1'b0); cyc(); idle(); cyc();
        chk("early_stop_busy", busy, 1);
        cyc();
        drive(1'b0, 2'd0, 0, 1'b1); cyc(); idle();
        chk("early_stop_enable", enable, 0);
        chk("early_stop_busy_off", busy, 0);

        // Write coincident with period_done, then reset mid-RUN.
        drive(1'b1, 2'd0, 1, 1'b0); cyc(); idle(); cyc(); cyc();
        drive(1'b1, 2'd2, 70, 1'b0); cyc();
        drive(1'b1, 2'd2, 80, 1'b1); cyc();
        chk("coinc_duty", duty_cycle, 70);
        chk("coinc_upd", upd_done, 1);
        idle(); rd_addr = 2'd0; cyc();
        chk("coinc_ctrl_dirty", rd_data, 21);
        drive(1'b0, 2'd0, 0, 1'b1); cyc(); idle();
        chk("coinc_next_duty", duty_cycle, 80);
        chk("coinc_next_upd", upd_done, 1);
        reset = 1'b1; cyc();
        chk("midrst_enable", enable, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_duty", duty_cycle, 0);
        chk("midrst_period", period, 0);
        chk("midrst_presc", prescaler, 0);
        chk("midrst_ready", cfg_ready, 1);
        chk("midrst_rd", rd_data, 0);
        reset = 1'b0; rd_addr = 2'd2; cyc();
        chk("midrst_shadow", rd_data, 0);
        $display("[TB] coincident write and mid-run reset done");

        // Randomized traffic against the behavioural model.
        reset = 1'b1; idle(); rd_addr = 2'd0;
        model_edge(1'b1, 1'b0, 2'd0, 0, 1'b0, 2'd0); cyc();
        reset = 1'b0;
        for (int c = 0; c < 2500; c++) begin
            r_rst = ($urandom_range(0, 399) == 0);
            r_v   = ($urandom_range(0, 3) == 0);
            r_a   = 2'($urandom_range(0, 3));
            r_pd  = ($urandom_range(0, 7) == 0);
            r_ra  = 2'($urandom_range(0, 3));
            if (r_a == 2'd0) r_d = int'($urandom_range(0, 1)) * 2 + (($urandom_range(0, 9) != 0) ? 1 : 0);
            else if (r_a == 2'd3) r_d = int'($urandom_range(0, 65535));
            else r_d = int'($urandom_range(0, 300));
            drive(r_v, r_a, r_d, r_pd);
            reset = r_rst;
            rd_addr = r_ra;
            if (r_v && !r_rst && m_mode != M_STOP)
                $display("[TB] rnd %0d: write addr=%0d data=%0d pd=%0d", c, r_a, r_d, r_pd);
            model_edge(r_rst, r_v, r_a, r_d, r_pd, r_ra);
            cyc();
            chk("rnd_enable", enable, (m_mode == M_RUN || m_mode == M_STOP) ? 1 : 0);
            chk("rnd_busy", busy, (m_mode == M_START || m_mode == M_STOP) ? 1 : 0);
            chk("rnd_ready", cfg_ready, (m_mode != M_STOP) ? 1 : 0);
            chk("rnd_period", period, m_per);
            chk("rnd_duty", duty_cycle, m_duty);
            chk("rnd_presc", prescaler, m_pre);
            chk("rnd_upd", upd_done, m_upd);
            chk("rnd_rd", rd_data, m_rd);
        end
        reset = 1'b0;
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
